// File: rtl/qtz_seq_ctrl_pkg.sv
// Shared HDC constants, chunk-count helper and sequencer state encoding.
package qtz_seq_ctrl_pkg;

  localparam int unsigned HV_DIM          = 10000;
  localparam int unsigned FEATURES_PER_CC = 59;
  localparam int unsigned NUM_FEATURES    = 617;
  localparam int unsigned NUM_SEGMENTS    = 4;

  // Number of capture chunks needed to cover all features of one sample.
  function automatic int unsigned num_chunks(input int unsigned nf, input int unsigned fpc);
    return (nf + fpc - 1) / fpc;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } qtz_state_e;

endpackage

// File: rtl/qtz_seq_ctrl_lat_cnt.sv
// Item-memory latency down-counter: loads a fixed value, counts to zero and holds.
module lat_cnt #(
  parameter int unsigned W        = 3,
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_load,
  output logic o_zero_c
);

  logic [W-1:0] r_cnt;

  // Load on request, otherwise decrement until zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/qtz_seq_ctrl.sv
// Quantizer sequencer: walks chunks (inner) and segments (outer) of one sample,
// strobing item-memory fetch and quantizer-register capture, then handshakes
// each captured chunk with the encoder. Control only, no datapath.
module qtz_seq_ctrl #(
  parameter int unsigned FEATURES_PER_CC = qtz_seq_ctrl_pkg::FEATURES_PER_CC,
  parameter int unsigned NUM_FEATURES    = qtz_seq_ctrl_pkg::NUM_FEATURES,
  parameter int unsigned NUM_SEGMENTS    = qtz_seq_ctrl_pkg::NUM_SEGMENTS,
  parameter int unsigned IM_LATENCY      = 2,
  localparam int unsigned NUM_CHUNKS     = qtz_seq_ctrl_pkg::num_chunks(NUM_FEATURES, FEATURES_PER_CC),
  localparam int unsigned CW             = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
  localparam int unsigned SW             = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1,
  localparam int unsigned LW             = $clog2(FEATURES_PER_CC + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  input  logic          enc_ready,
  output logic          im_rd_en,
  output logic [CW-1:0] im_chunk_idx,
  output logic [SW-1:0] im_seg_idx,
  output logic          mapping_hv_segment,
  output logic          qtz_out_reg_en,
  output logic          out_valid,
  output logic [LW-1:0] valid_lanes,
  output logic          last_chunk,
  output logic          last_seg,
  output logic          busy,
  output logic          done
);

  import qtz_seq_ctrl_pkg::*;

  localparam int unsigned LAT_W      = 3;
  localparam int unsigned LAST_LANES = NUM_FEATURES - (NUM_CHUNKS - 1) * FEATURES_PER_CC;

  qtz_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_chunk, w_chunk_nxt;
  logic [SW-1:0] r_seg, w_seg_nxt;
  logic          w_lat_zero, w_lat_load, w_last_chunk, w_last_seg;
  logic          r_im_rd_en, r_qtz_en, r_out_valid, r_mapping, r_busy, r_done;
  logic          r_last_chunk, r_last_seg;
  logic [LW-1:0] r_valid_lanes;

  assign w_last_chunk = (r_chunk == CW'(NUM_CHUNKS - 1));
  assign w_last_seg   = (r_seg == SW'(NUM_SEGMENTS - 1));
  // Counter holds IM_LATENCY-1 during FETCH and reaches zero on the last WAIT cycle.
  assign w_lat_load   = (w_state_nxt == ST_FETCH);

  lat_cnt #(
    .W        (LAT_W),
    .LOAD_VAL (IM_LATENCY - 1)
  ) u_lat_cnt (
    .clk      (clk),
    .nrst     (nrst),
    .i_load   (w_lat_load),
    .o_zero_c (w_lat_zero)
  );

  // State and position counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_chunk <= '0;
      r_seg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chunk <= w_chunk_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  // Next-state and counter advance; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_chunk_nxt = r_chunk;
    w_seg_nxt   = r_seg;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = w_lat_zero ? ST_LOAD : ST_WAIT;
      ST_WAIT:  if (w_lat_zero) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (enc_ready) begin
          if (!w_last_chunk) begin
            w_chunk_nxt = r_chunk + CW'(1);
            w_state_nxt = ST_FETCH;
          end else if (!w_last_seg) begin
            w_chunk_nxt = '0;
            w_seg_nxt   = r_seg + SW'(1);
            w_state_nxt = ST_FETCH;
          end else begin
            w_chunk_nxt = '0;
            w_seg_nxt   = '0;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_chunk_nxt = '0;
        w_seg_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_chunk_nxt = '0;
        w_seg_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      w_chunk_nxt = '0;
      w_seg_nxt   = '0;
      w_state_nxt = ST_IDLE;
    end
  end

  // Outputs registered from the next state/counters so they align with the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_im_rd_en    <= 1'b0;
      r_qtz_en      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_mapping     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_last_chunk  <= 1'b0;
      r_last_seg    <= 1'b0;
      r_valid_lanes <= LW'(FEATURES_PER_CC);
    end else begin
      r_im_rd_en    <= (w_state_nxt == ST_FETCH);
      r_qtz_en      <= (w_state_nxt == ST_LOAD);
      r_out_valid   <= (w_state_nxt == ST_HOLD);
      r_mapping     <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_WAIT) ||
                       (w_state_nxt == ST_LOAD)  || (w_state_nxt == ST_HOLD);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_done        <= (w_state_nxt == ST_DONE);
      r_last_chunk  <= (w_chunk_nxt == CW'(NUM_CHUNKS - 1));
      r_last_seg    <= (w_seg_nxt == SW'(NUM_SEGMENTS - 1));
      r_valid_lanes <= (w_chunk_nxt == CW'(NUM_CHUNKS - 1)) ? LW'(LAST_LANES)
                                                             : LW'(FEATURES_PER_CC);
    end
  end

  assign im_rd_en           = r_im_rd_en;
  assign im_chunk_idx       = r_chunk;
  assign im_seg_idx         = r_seg;
  assign mapping_hv_segment = r_mapping;
  assign qtz_out_reg_en     = r_qtz_en;
  assign out_valid          = r_out_valid;
  assign valid_lanes        = r_valid_lanes;
  assign last_chunk         = r_last_chunk;
  assign last_seg           = r_last_seg;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_qtz_seq_ctrl.sv
// Bench for qtz_seq_ctrl: expected chunk table pushed to a scoreboard on start,
// popped on each encoder handshake, plus hand-written stall/abort/reset sequences.
module tb_qtz_seq_ctrl;

  typedef struct {
    int seg;
    int chunk;
    int lanes;
    int lc;
    int ls;
  } exp_t;

  logic       clk;
  logic       nrst, start, start_l1, abort, enc_ready;
  logic       im_rd_en, mapping_hv_segment, qtz_out_reg_en, out_valid;
  logic       last_chunk, last_seg, busy, done;
  logic [3:0] im_chunk_idx;
  logic [1:0] im_seg_idx;
  logic [5:0] valid_lanes;
  logic       rd_l1, map_l1, ld_l1, ov_l1, lc_l1, ls_l1, busy_l1, done_l1;
  logic [3:0] chunk_l1;
  logic [1:0] seg_l1;
  logic [5:0] lanes_l1;

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, s_cyc = 0;
  int   first_rd, first_ld, first_ov, cnt_rd, cnt_ld, cnt_done, done_cyc, last_hs;
  int   first2_rd, first2_ld, cnt2_ld, cnt2_done;
  exp_t tbl[44];
  exp_t sb[$];
  exp_t e;

  qtz_seq_ctrl u_dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .enc_ready(enc_ready),
    .im_rd_en(im_rd_en), .im_chunk_idx(im_chunk_idx), .im_seg_idx(im_seg_idx),
    .mapping_hv_segment(mapping_hv_segment), .qtz_out_reg_en(qtz_out_reg_en),
    .out_valid(out_valid), .valid_lanes(valid_lanes), .last_chunk(last_chunk),
    .last_seg(last_seg), .busy(busy), .done(done)
  );

  qtz_seq_ctrl #(.IM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .nrst(nrst), .start(start_l1), .abort(1'b0), .enc_ready(1'b1),
    .im_rd_en(rd_l1), .im_chunk_idx(chunk_l1), .im_seg_idx(seg_l1),
    .mapping_hv_segment(map_l1), .qtz_out_reg_en(ld_l1),
    .out_valid(ov_l1), .valid_lanes(lanes_l1), .last_chunk(lc_l1),
    .last_seg(ls_l1), .busy(busy_l1), .done(done_l1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - s_cyc);
    end
  endtask

  // Event monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (im_rd_en) begin
      cnt_rd++;
      if (first_rd < 0) first_rd = cyc - s_cyc;
    end
    if (qtz_out_reg_en) begin
      cnt_ld++;
      if (first_ld < 0) first_ld = cyc - s_cyc;
    end
    if (out_valid && first_ov < 0) first_ov = cyc - s_cyc;
    if (done) begin
      cnt_done++;
      done_cyc = cyc - s_cyc;
    end
    if (rd_l1 && first2_rd < 0) first2_rd = cyc - s_cyc;
    if (ld_l1) begin
      cnt2_ld++;
      if (first2_ld < 0) first2_ld = cyc - s_cyc;
    end
    if (done_l1) cnt2_done++;
    if (out_valid && enc_ready) begin
      last_hs = cyc - s_cyc;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: handshake with empty scoreboard at seg %0d chunk %0d",
                 im_seg_idx, im_chunk_idx);
      end else begin
        e = sb.pop_front();
        chk("hs_seg",        32'(im_seg_idx),   e.seg);
        chk("hs_chunk",      32'(im_chunk_idx), e.chunk);
        chk("hs_valid_lanes", 32'(valid_lanes), e.lanes);
        chk("hs_last_chunk", 32'(last_chunk),   e.lc);
        chk("hs_last_seg",   32'(last_seg),     e.ls);
      end
    end
  end

  // Issue a one-cycle start (called just after a rising edge) and load the scoreboard.
  task automatic kick(input bit also_l1);
    first_rd = -1; first_ld = -1; first_ov = -1;
    cnt_rd = 0; cnt_ld = 0; cnt_done = 0; done_cyc = -1; last_hs = -1;
    first2_rd = -1; first2_ld = -1; cnt2_ld = 0; cnt2_done = 0;
    s_cyc = cyc;
    foreach (tbl[i]) sb.push_back(tbl[i]);
    start = 1'b1;
    start_l1 = also_l1;
    @(posedge clk); #1;
    start = 1'b0;
    start_l1 = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (cnt_done == 0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (cnt_done == 0) $display("FAIL wait_done: no done pulse within %0d cycles", lim);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_im_rd_en"}, 32'(im_rd_en), 0);
    chk({tag, "_qtz_en"},   32'(qtz_out_reg_en), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_mapping"},  32'(mapping_hv_segment), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_chunk"},    32'(im_chunk_idx), 0);
    chk({tag, "_seg"},      32'(im_seg_idx), 0);
    chk({tag, "_lanes"},    32'(valid_lanes), 59);
  endtask

  initial begin
    // Expected chunk sequence for one sample: chunk inner, segment outer.
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 11; c++) begin
        tbl[s*11+c].seg   = s;
        tbl[s*11+c].chunk = c;
        tbl[s*11+c].lanes = (c == 10) ? 27 : 59;
        tbl[s*11+c].lc    = (c == 10) ? 1 : 0;
        tbl[s*11+c].ls    = (s == 3) ? 1 : 0;
      end
    end
    first_rd = -1; first_ld = -1; first_ov = -1; first2_rd = -1; first2_ld = -1;
    cnt_rd = 0; cnt_ld = 0; cnt_done = 0; cnt2_ld = 0; cnt2_done = 0;
    nrst = 1'b0; start = 1'b0; start_l1 = 1'b0; abort = 1'b0; enc_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    idle_chk("reset");
    chk("reset_last_chunk", 32'(last_chunk), 0);
    chk("reset_last_seg",   32'(last_seg), 0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Free-running sample with stray starts mid-sample (cycle 50) and in DONE (cycle 177).
    kick(1'b0);
    for (int k = 2; k <= 200; k++) begin
      @(posedge clk); #1;
      start = (k == 50 || k == 177);
    end
    start = 1'b0;
    chk("t1_first_rd", first_rd, 1);
    chk("t1_first_ld", first_ld, 3);
    chk("t1_first_ov", first_ov, 4);
    chk("t1_captures", cnt_ld, 44);
    chk("t1_fetches",  cnt_rd, 44);
    chk("t1_done_cnt", cnt_done, 1);
    chk("t1_done_cyc", done_cyc, 177);
    chk("t1_done_after_hs", done_cyc, last_hs + 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // Encoder stall on chunk 2 of segment 0, plus DONE-cycle output checks.
    @(posedge clk); #1;
    kick(1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(qtz_out_reg_en && im_chunk_idx == 4'd2 && im_seg_idx == 2'd0) && n < 50);
      chk("t2_reach_chunk2", 32'(n < 50), 1);
    end
    @(posedge clk); #1;
    enc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_stall_out_valid", 32'(out_valid), 1);
      chk("t2_stall_no_rd",     32'(im_rd_en), 0);
      chk("t2_stall_chunk",     32'(im_chunk_idx), 2);
    end
    @(posedge clk); #1;
    enc_ready = 1'b1;
    @(negedge clk);
    chk("t2_hs_chunk", 32'(im_chunk_idx), 2);
    begin
      int n = 0;
      while (!done && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t2_done_mapping", 32'(mapping_hv_segment), 0);
    chk("t2_done_flag",    32'(done), 1);
    chk("t2_done_busy",    32'(busy), 1);
    chk("t2_done_lanes",   32'(valid_lanes), 59);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_captures", cnt_ld, 44);
    chk("t2_done_cnt", cnt_done, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Abort in WAIT of segment 1 chunk 5, then restart from the beginning.
    kick(1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(im_rd_en && im_seg_idx == 2'd1 && im_chunk_idx == 4'd5) && n < 200);
      chk("t3_reach_s1c5", 32'(n < 200), 1);
    end
    @(posedge clk); #1;
    chk("t3_wait_mapping", 32'(mapping_hv_segment), 1);
    chk("t3_wait_no_ld",   32'(qtz_out_reg_en), 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    idle_chk("t3_after_abort");
    repeat (10) @(posedge clk);
    #1;
    chk("t3_captures", cnt_ld, 16);
    chk("t3_no_done",  cnt_done, 0);
    sb.delete();
    kick(1'b0);
    wait_done(300);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_re_captures", cnt_ld, 44);
    chk("t3_re_done_cnt", cnt_done, 1);
    chk("t3_re_sb_empty", sb.size(), 0);

    // Asynchronous reset while holding a chunk.
    enc_ready = 1'b0;
    kick(1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 20);
      chk("t4_reach_hold", 32'(out_valid), 1);
    end
    #2;
    nrst = 1'b0;
    #1;
    idle_chk("t4_async_reset");
    sb.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    enc_ready = 1'b1;
    @(posedge clk); #1;

    // Rerun both instances; IM_LATENCY=1 captures one cycle after the fetch.
    kick(1'b1);
    wait_done(300);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_first_rd",   first_rd, 1);
    chk("t5_captures",   cnt_ld, 44);
    chk("t5_done_cnt",   cnt_done, 1);
    chk("t5_sb_empty",   sb.size(), 0);
    chk("t5_l1_first_rd", first2_rd, 1);
    chk("t5_l1_first_ld", first2_ld, 2);
    chk("t5_l1_captures", cnt2_ld, 44);
    chk("t5_l1_done_cnt", cnt2_done, 1);
    chk("t5_l1_idle",     32'(busy_l1 | map_l1 | ov_l1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qtz_seq_ctrl.md
QTZ_SEQ_CTRL -- requirements
Module: qtz_seq_ctrl

Interface
REQ-001 Parameter FEATURES_PER_CC, default 59: feature lanes loaded per quantizer-register capture.
REQ-002 Parameter NUM_FEATURES, default 617: features per input sample.
REQ-003 Parameter NUM_SEGMENTS, default 4: HV segments mapped per sample.
REQ-004 Parameter IM_LATENCY, default 2: cycles from im_rd_en to valid im_fetch_outputs; legal range 1..8.
REQ-005 Derived constant NUM_CHUNKS = ceil(NUM_FEATURES/FEATURES_PER_CC), 11 at defaults.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock.
REQ-007 nrst, input, 1, asynchronous active-low reset.
REQ-008 start, input, 1, one-cycle request to map one sample.
REQ-009 abort, input, 1, synchronous cancel of the sample in flight.
REQ-010 enc_ready, input, 1, encoder accepts the current level_hvs chunk.
REQ-011 im_rd_en, output, 1, one-cycle item-memory fetch strobe.
REQ-012 im_chunk_idx, output, $clog2(NUM_CHUNKS), chunk being fetched.
REQ-013 im_seg_idx, output, $clog2(NUM_SEGMENTS), segment being fetched.
REQ-014 mapping_hv_segment, output, 1, high while a sample is being mapped.
REQ-015 qtz_out_reg_en, output, 1, one-cycle capture strobe to the quantizer output register.
REQ-016 out_valid, output, 1, captured chunk available to the encoder.
REQ-017 valid_lanes, output, $clog2(FEATURES_PER_CC+1), lanes meaningful in the current chunk.
REQ-018 last_chunk / last_seg, output, 1 each, current chunk is the final chunk / final segment.
REQ-019 busy, output, 1, FSM not IDLE; done, output, 1, one-cycle end-of-sample pulse.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, WAIT, LOAD, HOLD, DONE.
REQ-021 IDLE->FETCH on start; start SHALL be ignored in every other state.
REQ-022 FETCH SHALL last one cycle with im_rd_en=1 and then enter WAIT.
REQ-023 WAIT SHALL last IM_LATENCY-1 cycles (zero for IM_LATENCY=1), so LOAD occurs exactly IM_LATENCY cycles after FETCH.
REQ-024 LOAD SHALL last one cycle with qtz_out_reg_en=1, then enter HOLD.
REQ-025 HOLD SHALL drive out_valid=1 and remain until enc_ready=1; the chunk counter SHALL advance only on out_valid&&enc_ready.
REQ-026 Iteration order SHALL be chunk-inner, segment-outer: chunk 0..NUM_CHUNKS-1 for segment 0, then segment 1, and so on.
REQ-027 On the HOLD handshake, if chunks remain: next state FETCH the following cycle; if final chunk of final segment: DONE.
REQ-028 DONE SHALL last one cycle with done=1 and return to IDLE; a start in DONE SHALL be ignored.
REQ-029 mapping_hv_segment SHALL be 1 in FETCH, WAIT, LOAD and HOLD, and 0 in IDLE and DONE.
REQ-030 valid_lanes SHALL equal FEATURES_PER_CC, except NUM_FEATURES-(NUM_CHUNKS-1)*FEATURES_PER_CC on the last chunk (27 at defaults); no zero value when the division is exact.
REQ-031 Counters SHALL wrap: chunk NUM_CHUNKS-1 goes to 0 with the segment increment; both go to 0 on DONE.
REQ-032 abort SHALL take priority over all transitions and force IDLE next cycle with counters cleared and no done pulse.
REQ-033 abort during LOAD SHALL still permit that cycle's qtz_out_reg_en; out_valid SHALL be 0 from the following cycle.
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no combinational path from enc_ready.

Reset
REQ-035 On nrst low: state IDLE, counters 0, and all outputs 0 except valid_lanes=FEATURES_PER_CC, asynchronously.
REQ-036 Reset mid-sample SHALL discard progress; the first start after release SHALL begin at segment 0, chunk 0.

Structure
REQ-037 FEATURES_PER_CC, HV_DIM, NUM_FEATURES, NUM_SEGMENTS, the NUM_CHUNKS function and the state enum SHALL reside in the shared HDC package.
REQ-038 The latency counter SHALL be a sub-module lat_cnt (load IM_LATENCY-1, count down, zero flag).
REQ-039 qtz_seq_ctrl SHALL contain no datapath; it drives qtz_reg_out_* enables only.

Verification
REQ-040 Start at cycle 0, enc_ready tied 1, defaults: im_rd_en at cycle 1, qtz_out_reg_en at 3, out_valid at 4, 44 captures, done once.
REQ-041 enc_ready low for 5 cycles in chunk 2 HOLD: out_valid held; no im_rd_en; chunk index stays 2 until handshake.
REQ-042 Last chunk of segment 3: valid_lanes=27, last_chunk=1, last_seg=1; done the cycle after handshake; mapping_hv_segment low in DONE.
REQ-043 abort in WAIT of segment 1 chunk 5: IDLE next cycle, no qtz_out_reg_en, no done; new start resumes from seg 0 chunk 0.
REQ-044 start pulsed mid-sample and in DONE: ignored, capture count unchanged at 44.
REQ-045 nrst asserted in HOLD: outputs clear immediately; IM_LATENCY=1 rerun shows qtz_out_reg_en 1 cycle after im_rd_en.
